lsq_param: RTL and testbench
============================

LSQ_PARAM -- requirements
Module: lsq_param

Interface
REQ-001 Parameter DEPTH, 16, queue entries; power of two, 4..64.
REQ-002 Parameter ROB_W, 4, ROB tag width; tag 0 means "no dependency".
REQ-003 Parameter N_CDB, 2, number of CDB broadcast channels, 1..4.
REQ-004 Parameter FULL_MARGIN, 2, free-slot reserve before full asserts.
REQ-005 Ports, one per line:
 clk  in  1  clock
 rst  in  1  synchronous reset, active-high
 rdy  in  1  global stall; low freezes all state and outputs
 disp_en  in  1  dispatch one entry this cycle
 disp_op  in  4  [3] store, [2] unsigned load, [1:0] size 0=B 1=H 2=W
 disp_q1/disp_q2  in  ROB_W  base/data source tags
 disp_v1/disp_v2  in  32  base/data values
 disp_imm  in  32  address offset
 disp_rob  in  ROB_W  ROB tag of entry
 cdb_valid  in  N_CDB  per-channel broadcast valid
 cdb_rob  in  N_CDB*ROB_W  per-channel tags, channel k at [k*ROB_W +: ROB_W]
 cdb_data  in  N_CDB*32  per-channel results
 commit_en  in  1  ROB retires commit_rob this cycle
 commit_rob  in  ROB_W  retiring tag
 io_rob  in  ROB_W  ROB tag currently at ROB head
 flush  in  1  misprediction flush
 lsu_busy  in  1  LSU cannot accept
 lsu_en  out  1  one-cycle issue strobe
 lsu_op  out  4  issued opcode
 lsu_addr  out  32  v1+imm, modulo 2^32
 lsu_data  out  32  store data, 0 for loads
 lsu_rob  out  ROB_W  issued entry's tag
 io_head_rob  out  ROB_W  head tag when head address is IO region, else 0
 full  out  1  count >= DEPTH-FULL_MARGIN
 count  out  $clog2(DEPTH)+1  occupied entries

Function
REQ-006 Circular queue, head/tail pointers wrap DEPTH-1 -> 0; entries occupy [head, tail).
REQ-007 disp_en writes entry at tail, tail advances next cycle; dispatcher never asserts disp_en while full.
REQ-008 Every cycle, each valid CDB channel whose tag equals a nonzero entry q1/q2 clears that q and loads the value; channel k+1 wins over k on equal tags.
REQ-009 commit_en marks the occupied store entry with rob==commit_rob as committed; loads ignore commit.
REQ-010 Head issues only when occupied, q1==0, q2==0, !lsu_busy, and: store -> committed; load -> address not IO, or io_rob==head rob.
REQ-011 IO region: lsu_addr[17:16]==2'b11 (0x30000-0x3FFFF).
REQ-012 Issue: lsu_en=1 for exactly one cycle, lsu_op/addr/data/rob registered in same edge, entry freed, head advances; max one issue per cycle.
REQ-013 Simultaneous dispatch and issue leave count unchanged; dispatch into the slot freed same cycle is legal.
REQ-014 flush: uncommitted entries discarded, tail <= head + committed-store count (committed stores are contiguous from head), count updated accordingly; committed stores still drain; dispatch ignored that cycle; lsu_en from that edge is 0 unless a committed store issues.
REQ-015 commit_en and flush same cycle: commit applied first, committed entry survives flush.
REQ-016 count and full are registered; full may lag one cycle, FULL_MARGIN covers this.

Reset
REQ-017 rst: head=tail=0, count=0, all entries free and uncommitted, lsu_en=0, lsu_op/addr/data/rob=0, full=0; rst dominates flush and rdy.
REQ-018 rst mid-issue: lsu_en low on next edge, in-flight entry lost.

Configuration
REQ-019 LSQ_CDB_BYPASS_EN defined: disp_q1/q2 matching a same-cycle valid CDB tag are stored as 0 with CDB data; undefined: dispatch fields stored verbatim, dispatcher must supply resolved operands.

Verification
REQ-020 Load, q=0, v1=0x1000, imm=4, lsu_busy=0 -> lsu_en next cycle, lsu_addr=0x1004, lsu_data=0.
REQ-021 Store rob=3 ready, no commit 5 cycles -> no issue; commit_rob=3 -> lsu_en one cycle later, lsu_data=v2.
REQ-022 Load q1=5; cdb_valid[1]=1, tag 5, data 0x200, imm 0 -> issue lsu_addr=0x200.
REQ-023 Fill DEPTH-2 entries (DEPTH=16) -> full=1; fill 16 with dispatch+issue across wrap -> pointers wrap, order preserved.
REQ-024 Committed store + 3 uncommitted loads, flush -> count=1, store issues, loads never issued.
REQ-025 Load at address 0x30000, io_rob!=tag -> stalls; io_rob==tag -> issues; io_head_rob equals tag throughout.

Source files
------------

// File: rtl/lsq_param.sv
// Parameterised in-order load/store queue with CDB operand capture, store commit, IO gating and flush.
// Optional macro LSQ_CDB_BYPASS_EN: resolve dispatch tags against same-cycle CDB broadcasts.
module lsq_param #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned ROB_W       = 4,
   parameter int unsigned N_CDB       = 2,
   parameter int unsigned FULL_MARGIN = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    disp_en,
   input  logic [3:0]              disp_op,
   input  logic [ROB_W-1:0]        disp_q1,
   input  logic [ROB_W-1:0]        disp_q2,
   input  logic [31:0]             disp_v1,
   input  logic [31:0]             disp_v2,
   input  logic [31:0]             disp_imm,
   input  logic [ROB_W-1:0]        disp_rob,
   input  logic [N_CDB-1:0]        cdb_valid,
   input  logic [N_CDB*ROB_W-1:0]  cdb_rob,
   input  logic [N_CDB*32-1:0]     cdb_data,
   input  logic                    commit_en,
   input  logic [ROB_W-1:0]        commit_rob,
   input  logic [ROB_W-1:0]        io_rob,
   input  logic                    flush,
   input  logic                    lsu_busy,
   output logic                    lsu_en,
   output logic [3:0]              lsu_op,
   output logic [31:0]             lsu_addr,
   output logic [31:0]             lsu_data,
   output logic [ROB_W-1:0]        lsu_rob,
   output logic [ROB_W-1:0]        io_head_rob,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic             valid;
      logic             comm;
      logic [3:0]       op;
      logic [ROB_W-1:0] q1;
      logic [ROB_W-1:0] q2;
      logic [ROB_W-1:0] rob;
      logic [31:0]      v1;
      logic [31:0]      v2;
      logic [31:0]      imm;
   } entry_t;

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d, ccnt;
   logic             full_q, full_d;
   logic             lsu_en_q, lsu_en_d;
   logic [3:0]       lsu_op_q, lsu_op_d;
   logic [31:0]      lsu_addr_q, lsu_addr_d, lsu_data_q, lsu_data_d;
   logic [ROB_W-1:0] lsu_rob_q, lsu_rob_d;

   entry_t           hd;
   logic [31:0]      head_addr;
   logic             head_io, head_rdy, issue;

   always_comb begin
      hd        = ent_q[head_q];
      head_addr = hd.v1 + hd.imm;
      head_io   = (head_addr[17:16] == 2'b11);
      head_rdy  = hd.valid && (hd.q1 == '0) && (hd.q2 == '0) && !lsu_busy &&
                  (hd.op[3] ? hd.comm : (!head_io || (io_rob == hd.rob)));
      // During flush only an already-committed store may leave the head
      issue     = head_rdy && (!flush || hd.op[3]);
   end

   assign io_head_rob = (hd.valid && (hd.q1 == '0) && head_io) ? hd.rob : '0;

   always_comb begin
      ent_d      = ent_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      ccnt       = '0;
      lsu_en_d   = 1'b0;
      lsu_op_d   = lsu_op_q;
      lsu_addr_d = lsu_addr_q;
      lsu_data_d = lsu_data_q;
      lsu_rob_d  = lsu_rob_q;

      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (ent_q[i].valid) begin
            // Compare against the stored tag so a later channel overrides an earlier one
            for (int unsigned k = 0; k < N_CDB; k++) begin
               if (cdb_valid[k]) begin
                  if ((ent_q[i].q1 != '0) && (cdb_rob[k*ROB_W +: ROB_W] == ent_q[i].q1)) begin
                     ent_d[i].q1 = '0;
                     ent_d[i].v1 = cdb_data[k*32 +: 32];
                  end
                  if ((ent_q[i].q2 != '0) && (cdb_rob[k*ROB_W +: ROB_W] == ent_q[i].q2)) begin
                     ent_d[i].q2 = '0;
                     ent_d[i].v2 = cdb_data[k*32 +: 32];
                  end
               end
            end
            if (commit_en && ent_q[i].op[3] && (ent_q[i].rob == commit_rob))
               ent_d[i].comm = 1'b1;
         end
      end

      if (issue) begin
         ent_d[head_q].valid = 1'b0;
         ent_d[head_q].comm  = 1'b0;
         head_d              = head_q + PTR_W'(1);
         lsu_en_d            = 1'b1;
         lsu_op_d            = hd.op;
         lsu_addr_d          = head_addr;
         lsu_data_d          = hd.op[3] ? hd.v2 : '0;
         lsu_rob_d           = hd.rob;
      end

      if (flush) begin
         // Surviving committed stores are contiguous from the (possibly advanced) head
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_d[i].valid && ent_d[i].comm) begin
               ccnt = ccnt + CNT_W'(1);
            end else begin
               ent_d[i].valid = 1'b0;
               ent_d[i].comm  = 1'b0;
            end
         end
         tail_d  = head_d + PTR_W'(ccnt);
         count_d = ccnt;
      end else begin
         if (disp_en) begin
            ent_d[tail_q].valid = 1'b1;
            ent_d[tail_q].comm  = 1'b0;
            ent_d[tail_q].op    = disp_op;
            ent_d[tail_q].q1    = disp_q1;
            ent_d[tail_q].q2    = disp_q2;
            ent_d[tail_q].rob   = disp_rob;
            ent_d[tail_q].v1    = disp_v1;
            ent_d[tail_q].v2    = disp_v2;
            ent_d[tail_q].imm   = disp_imm;
`ifdef LSQ_CDB_BYPASS_EN
            for (int unsigned k = 0; k < N_CDB; k++) begin
               if (cdb_valid[k]) begin
                  if ((disp_q1 != '0) && (cdb_rob[k*ROB_W +: ROB_W] == disp_q1)) begin
                     ent_d[tail_q].q1 = '0;
                     ent_d[tail_q].v1 = cdb_data[k*32 +: 32];
                  end
                  if ((disp_q2 != '0) && (cdb_rob[k*ROB_W +: ROB_W] == disp_q2)) begin
                     ent_d[tail_q].q2 = '0;
                     ent_d[tail_q].v2 = cdb_data[k*32 +: 32];
                  end
               end
            end
`else
`endif
            tail_d = tail_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(disp_en) - CNT_W'(issue);
      end

      full_d = (count_d >= CNT_W'(DEPTH - FULL_MARGIN));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         lsu_en_q   <= 1'b0;
         lsu_op_q   <= '0;
         lsu_addr_q <= '0;
         lsu_data_q <= '0;
         lsu_rob_q  <= '0;
      end else if (rdy) begin
         ent_q      <= ent_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         full_q     <= full_d;
         lsu_en_q   <= lsu_en_d;
         lsu_op_q   <= lsu_op_d;
         lsu_addr_q <= lsu_addr_d;
         lsu_data_q <= lsu_data_d;
         lsu_rob_q  <= lsu_rob_d;
      end
   end

   assign lsu_en   = lsu_en_q;
   assign lsu_op   = lsu_op_q;
   assign lsu_addr = lsu_addr_q;
   assign lsu_data = lsu_data_q;
   assign lsu_rob  = lsu_rob_q;
   assign full     = full_q;
   assign count    = count_q;

endmodule

// File: tb/tb_lsq_param.sv
// Scoreboard bench for lsq_param: expected issues queued when made legal, monitor checks every lsu_en.
module tb_lsq_param;
   logic        clk = 1'b0;
   logic        rst, rdy, disp_en, commit_en, flush, lsu_busy;
   logic [3:0]  disp_op, disp_q1, disp_q2, disp_rob, commit_rob, io_rob;
   logic [31:0] disp_v1, disp_v2, disp_imm;
   logic [1:0]  cdb_valid;
   logic [7:0]  cdb_rob;
   logic [63:0] cdb_data;
   logic        lsu_en, full;
   logic [3:0]  lsu_op, lsu_rob, io_head_rob;
   logic [31:0] lsu_addr, lsu_data;
   logic [4:0]  count;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  rob;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   lsq_param #(.DEPTH(16), .ROB_W(4), .N_CDB(2), .FULL_MARGIN(2)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .disp_en(disp_en), .disp_op(disp_op), .disp_q1(disp_q1), .disp_q2(disp_q2),
      .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_imm(disp_imm), .disp_rob(disp_rob),
      .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
      .commit_en(commit_en), .commit_rob(commit_rob), .io_rob(io_rob),
      .flush(flush), .lsu_busy(lsu_busy),
      .lsu_en(lsu_en), .lsu_op(lsu_op), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
      .lsu_rob(lsu_rob), .io_head_rob(io_head_rob), .full(full), .count(count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (lsu_en) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_issue: got op=%h addr=%h data=%h rob=%0d, none expected",
                     lsu_op, lsu_addr, lsu_data, lsu_rob);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if ({lsu_op, lsu_addr, lsu_data, lsu_rob} !== e) begin
               n_err++;
               $display("FAIL issue_payload: got op=%h addr=%h data=%h rob=%0d, want op=%h addr=%h data=%h rob=%0d",
                        lsu_op, lsu_addr, lsu_data, lsu_rob, e.op, e.addr, e.data, e.rob);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dispatch(input logic [3:0] op, input logic [3:0] q1, input logic [3:0] q2,
                           input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                           input logic [3:0] rob);
      disp_en = 1'b1; disp_op = op; disp_q1 = q1; disp_q2 = q2;
      disp_v1 = v1; disp_v2 = v2; disp_imm = imm; disp_rob = rob;
      tick();
      disp_en = 1'b0;
   endtask

   task automatic drained(input string name);
      @(negedge clk);
      #1;
      chk(name, sb.size(), 0);
   endtask

   task automatic wait_drain(input string name, input int unsigned max_cyc);
      for (int unsigned c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0) break;
      end
      chk(name, sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; rdy = 1'b1; disp_en = 1'b0; commit_en = 1'b0; flush = 1'b0; lsu_busy = 1'b0;
      disp_op = '0; disp_q1 = '0; disp_q2 = '0; disp_rob = '0; commit_rob = '0; io_rob = '0;
      disp_v1 = '0; disp_v2 = '0; disp_imm = '0; cdb_valid = '0; cdb_rob = '0; cdb_data = '0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_count", count, 0);
      chk("rst_full", full, 0);
      chk("rst_lsu_en", lsu_en, 0);
      chk("rst_io_head", io_head_rob, 0);

      // Ready word load issues on the following edge, load data forced to zero
      sb.push_back('{4'h2, 32'h1004, 32'h0, 4'd1});
      dispatch(4'h2, 4'd0, 4'd0, 32'h1000, 32'h55, 32'd4, 4'd1);
      chk("load_count", count, 1);
      tick();
      chk("load_en", lsu_en, 1);
      drained("load_done");
      chk("load_count0", count, 0);

      // Store waits for commit
      dispatch(4'hA, 4'd0, 4'd0, 32'h2000, 32'hDEADBEEF, 32'd8, 4'd3);
      repeat (5) tick();
      chk("store_hold_cnt", count, 1);
      sb.push_back('{4'hA, 32'h2008, 32'hDEADBEEF, 4'd3});
      commit_en = 1'b1; commit_rob = 4'd3;
      tick();
      commit_en = 1'b0;
      chk("store_commit_en0", lsu_en, 0);
      tick();
      chk("store_issue_en", lsu_en, 1);
      tick();
      chk("store_pulse", lsu_en, 0);
      chk("store_sb", sb.size(), 0);

      // Load waiting on tag 5; both channels broadcast 5, channel 1 must win
      dispatch(4'h6, 4'd5, 4'd0, 32'h0, 32'h77, 32'h0, 4'd6);
      cdb_valid = 2'b11; cdb_rob = 8'h55; cdb_data = {32'h200, 32'h999};
      tick();
      cdb_valid = 2'b00;
      chk("cdb_wait", lsu_en, 0);
      sb.push_back('{4'h6, 32'h200, 32'h0, 4'd6});
      tick();
      chk("cdb_issue_en", lsu_en, 1);
      drained("cdb_done");

      // Fill with LSU busy, then drain across the pointer wrap while dispatching
      lsu_busy = 1'b1;
      for (int i = 0; i < 14; i++) begin
         sb.push_back('{4'h2, 32'(i) * 32'h100, 32'h0, 4'((i % 15) + 1)});
         dispatch(4'h2, 4'd0, 4'd0, 32'(i) * 32'h100, 32'h0, 32'h0, 4'((i % 15) + 1));
         if (i == 12) begin
            chk("fill13_count", count, 13);
            chk("fill13_full", full, 0);
         end
      end
      chk("fill14_count", count, 14);
      chk("fill14_full", full, 1);
      lsu_busy = 1'b0;
      tick();
      chk("drain1_count", count, 13);
      chk("drain1_full", full, 0);
      for (int i = 14; i < 16; i++) begin
         sb.push_back('{4'h2, 32'(i) * 32'h100, 32'h0, 4'((i % 15) + 1)});
         dispatch(4'h2, 4'd0, 4'd0, 32'(i) * 32'h100, 32'h0, 32'h0, 4'((i % 15) + 1));
         chk("disp_issue_count", count, 13);
      end
      wait_drain("wrap_drain", 40);
      tick();
      chk("wrap_count0", count, 0);

      // Flush keeps the committed store, drops loads and the same-cycle dispatch
      lsu_busy = 1'b1;
      dispatch(4'h9, 4'd0, 4'd0, 32'h4000, 32'h1234, 32'd2, 4'd7);
      dispatch(4'h0, 4'd0, 4'd0, 32'h5000, 32'h0, 32'd0, 4'd8);
      dispatch(4'h0, 4'd0, 4'd0, 32'h5004, 32'h0, 32'd0, 4'd9);
      dispatch(4'h0, 4'd0, 4'd0, 32'h5008, 32'h0, 32'd0, 4'd10);
      chk("flush_pre_count", count, 4);
      commit_en = 1'b1; commit_rob = 4'd7;
      tick();
      commit_en = 1'b0;
      flush = 1'b1;
      dispatch(4'h0, 4'd0, 4'd0, 32'h5010, 32'h0, 32'd0, 4'd14);
      flush = 1'b0;
      chk("flush_count", count, 1);
      sb.push_back('{4'h9, 32'h4002, 32'h1234, 4'd7});
      lsu_busy = 1'b0;
      tick();
      chk("flush_store_en", lsu_en, 1);
      drained("flush_done");
      repeat (4) tick();
      chk("flush_count0", count, 0);

      // Commit and flush in the same cycle: store survives
      lsu_busy = 1'b1;
      dispatch(4'hA, 4'd0, 4'd0, 32'h6000, 32'hCAFE, 32'd0, 4'd11);
      dispatch(4'h2, 4'd0, 4'd0, 32'h6100, 32'h0, 32'd0, 4'd12);
      commit_en = 1'b1; commit_rob = 4'd11; flush = 1'b1;
      tick();
      commit_en = 1'b0; flush = 1'b0;
      chk("cf_count", count, 1);
      sb.push_back('{4'hA, 32'h6000, 32'hCAFE, 4'd11});
      lsu_busy = 1'b0;
      wait_drain("cf_drain", 5);
      tick();
      chk("cf_count0", count, 0);

      // IO-region load stalls until it reaches the ROB head
      io_rob = 4'd0;
      dispatch(4'h2, 4'd0, 4'd0, 32'h30000, 32'h0, 32'd0, 4'd13);
      for (int c = 0; c < 3; c++) begin
         chk("io_head_rob", io_head_rob, 13);
         tick();
      end
      sb.push_back('{4'h2, 32'h30000, 32'h0, 4'd13});
      io_rob = 4'd13;
      tick();
      chk("io_issue_en", lsu_en, 1);
      drained("io_done");
      chk("io_head_clear", io_head_rob, 0);

      // rdy low freezes the queue
      dispatch(4'h2, 4'd0, 4'd0, 32'h700, 32'h0, 32'd0, 4'd2);
      rdy = 1'b0;
      repeat (3) tick();
      chk("stall_count", count, 1);
      sb.push_back('{4'h2, 32'h700, 32'h0, 4'd2});
      rdy = 1'b1;
      tick();
      chk("stall_release_en", lsu_en, 1);
      drained("stall_done");

      // Reset on the would-be issue edge discards the entry
      dispatch(4'h2, 4'd0, 4'd0, 32'h800, 32'h0, 32'd0, 4'd4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_en", lsu_en, 0);
      chk("rst_mid_count", count, 0);
      repeat (3) tick();
      chk("final_sb", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
